// File: rtl/cr_osf_ob_egress.sv
// OSF outbound egress: drains the merged FWFT FIFO into an AXI4-Stream master
// through a 2-entry buffer, with frame-boundary stall, framing checks and statistics.
//
// state       | meaning
// ST_IDLE     | between frames; the next word read should carry SOT
// ST_IN_FRAME | a frame has started and its EOT word has not been read yet
module cr_osf_ob_egress #(
    parameter int DATA_W = 64,
    parameter int USER_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    // packed axi4s_dp_bus_t layout: {tuser, tdata}
    input  logic [USER_W+DATA_W-1:0] ob_fifo_rdata,
    input  logic                     ob_fifo_empty,
    output logic                     ob_fifo_rd,
    output logic                     osf_ob_tvalid,
    input  logic                     osf_ob_tready,
    output logic [DATA_W-1:0]        osf_ob_tdata,
    output logic [USER_W-1:0]        osf_ob_tuser,
    output logic                     osf_ob_tlast,
    input  logic                     stall_req,
    input  logic                     stat_clr,
    output logic                     egress_idle,
    output logic [CNT_W-1:0]         beat_cnt,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic                     err_no_sot,
    output logic                     err_dup_sot
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_IN_FRAME = 1'b1;

    logic [0:0]        state;
    logic [1:0]        occ;
    logic [1:0]        occ_nxt;
    logic [DATA_W-1:0] data0, data1;
    logic [USER_W-1:0] user0, user1;
    logic [DATA_W-1:0] in_data;
    logic [USER_W-1:0] in_user;
    logic              in_sot, in_eot;
    logic              hold, push, pop;

    assign in_data = ob_fifo_rdata[DATA_W-1:0];
    assign in_user = ob_fifo_rdata[DATA_W +: USER_W];
    assign in_sot  = in_user[0];
    assign in_eot  = in_user[1];

    // Stall only takes effect between frames so a started frame always completes.
    assign hold       = stall_req && (state == ST_IDLE);
    assign ob_fifo_rd = !rst && !ob_fifo_empty && (occ != 2'd2) && !hold;
    assign push       = ob_fifo_rd;

    assign osf_ob_tvalid = (occ != 2'd0);
    assign osf_ob_tdata  = data0;
    assign osf_ob_tuser  = user0;
    assign osf_ob_tlast  = user0[1];
    assign pop           = osf_ob_tvalid && osf_ob_tready;

    assign egress_idle = (occ == 2'd0) && (state == ST_IDLE);

    always_comb begin
        occ_nxt = occ;
        if (push && !pop) begin
            occ_nxt = occ + 2'd1;
        end else if (!push && pop) begin
            occ_nxt = occ - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ   <= 2'd0;
            data0 <= '0;
            user0 <= '0;
            data1 <= '0;
            user1 <= '0;
        end else begin
            occ <= occ_nxt;
            // Head slot takes the incoming word when it would otherwise be empty.
            if (push && ((occ == 2'd0) || (occ == 2'd1 && pop))) begin
                data0 <= in_data;
                user0 <= in_user;
            end else if (pop && occ == 2'd2) begin
                data0 <= data1;
                user0 <= user1;
            end
            if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) begin
                data1 <= in_data;
                user1 <= in_user;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (push) begin
            // A word without EOT leaves a frame open, whether or not it was well formed.
            state <= in_eot ? ST_IDLE : ST_IN_FRAME;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_no_sot  <= 1'b0;
            err_dup_sot <= 1'b0;
            beat_cnt    <= '0;
            frame_cnt   <= '0;
        end else if (stat_clr) begin
            err_no_sot  <= 1'b0;
            err_dup_sot <= 1'b0;
            beat_cnt    <= '0;
            frame_cnt   <= '0;
        end else begin
            if (push && state == ST_IDLE && !in_sot) begin
                err_no_sot <= 1'b1;
            end
            if (push && state == ST_IN_FRAME && in_sot) begin
                err_dup_sot <= 1'b1;
            end
            if (pop) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (osf_ob_tlast) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cr_osf_ob_egress.sv
// Directed bench for cr_osf_ob_egress with a queue-based reference model
// checked every cycle on the falling edge.
module tb_cr_osf_ob_egress;

    localparam int DATA_W = 64;
    localparam int USER_W = 8;
    localparam int CNT_W  = 4;

    logic                     clk;
    logic                     rst;
    logic [USER_W+DATA_W-1:0] ob_fifo_rdata;
    logic                     ob_fifo_empty;
    logic                     ob_fifo_rd;
    logic                     osf_ob_tvalid;
    logic                     osf_ob_tready;
    logic [DATA_W-1:0]        osf_ob_tdata;
    logic [USER_W-1:0]        osf_ob_tuser;
    logic                     osf_ob_tlast;
    logic                     stall_req;
    logic                     stat_clr;
    logic                     egress_idle;
    logic [CNT_W-1:0]         beat_cnt;
    logic [CNT_W-1:0]         frame_cnt;
    logic                     err_no_sot;
    logic                     err_dup_sot;

    cr_osf_ob_egress #(.DATA_W(DATA_W), .USER_W(USER_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ob_fifo_rdata (ob_fifo_rdata),
        .ob_fifo_empty (ob_fifo_empty),
        .ob_fifo_rd    (ob_fifo_rd),
        .osf_ob_tvalid (osf_ob_tvalid),
        .osf_ob_tready (osf_ob_tready),
        .osf_ob_tdata  (osf_ob_tdata),
        .osf_ob_tuser  (osf_ob_tuser),
        .osf_ob_tlast  (osf_ob_tlast),
        .stall_req     (stall_req),
        .stat_clr      (stat_clr),
        .egress_idle   (egress_idle),
        .beat_cnt      (beat_cnt),
        .frame_cnt     (frame_cnt),
        .err_no_sot    (err_no_sot),
        .err_dup_sot   (err_dup_sot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source FIFO: stimulus appends at wr_idx, the source process consumes at rd_idx.
    logic [USER_W+DATA_W-1:0] src_mem [256];
    int  wr_idx = 0;
    int  rd_idx = 0;
    logic rd_pend = 1'b0;
    logic [63:0] data_seq = 64'hA5A5_0000_0000_0000;

    assign ob_fifo_empty = (rd_idx == wr_idx);
    assign ob_fifo_rdata = src_mem[rd_idx[7:0]];

    always @(posedge clk) begin
        #1;
        if (rst) rd_idx = wr_idx;
        else if (rd_pend) rd_idx = rd_idx + 1;
    end

    // Reference model: exp_q holds words accepted from the FIFO and not yet handed off.
    logic [USER_W+DATA_W-1:0] exp_q[$];
    logic                     m_in_frame = 1'b0;
    logic [CNT_W-1:0]         m_beat = '0;
    logic [CNT_W-1:0]         m_frame = '0;
    logic                     m_nosot = 1'b0;
    logic                     m_dup = 1'b0;
    logic                     m_rd, m_hs;
    logic [USER_W+DATA_W-1:0] w;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_tvalid", {63'b0, osf_ob_tvalid}, 64'd0);
            chk("rst_rd", {63'b0, ob_fifo_rd}, 64'd0);
            chk("rst_tdata", osf_ob_tdata, 64'd0);
            chk("rst_tuser", {56'b0, osf_ob_tuser}, 64'd0);
            chk("rst_tlast", {63'b0, osf_ob_tlast}, 64'd0);
            chk("rst_idle", {63'b0, egress_idle}, 64'd1);
            chk("rst_cnts", {56'b0, beat_cnt, frame_cnt}, 64'd0);
            chk("rst_errs", {62'b0, err_no_sot, err_dup_sot}, 64'd0);
            exp_q.delete();
            m_in_frame = 1'b0;
            m_beat = '0;
            m_frame = '0;
            m_nosot = 1'b0;
            m_dup = 1'b0;
            rd_pend = 1'b0;
        end else begin
            m_rd = !ob_fifo_empty && (exp_q.size() < 2) && !(stall_req && !m_in_frame);
            chk("fifo_rd", {63'b0, ob_fifo_rd}, {63'b0, m_rd});
            chk("tvalid", {63'b0, osf_ob_tvalid}, {63'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("tdata", osf_ob_tdata, exp_q[0][63:0]);
                chk("tuser", {56'b0, osf_ob_tuser}, {56'b0, exp_q[0][71:64]});
                chk("tlast", {63'b0, osf_ob_tlast}, {63'b0, exp_q[0][65]});
            end
            chk("idle", {63'b0, egress_idle}, {63'b0, (exp_q.size() == 0) && !m_in_frame});
            chk("beat_cnt", {60'b0, beat_cnt}, {60'b0, m_beat});
            chk("frame_cnt", {60'b0, frame_cnt}, {60'b0, m_frame});
            chk("err_no_sot", {63'b0, err_no_sot}, {63'b0, m_nosot});
            chk("err_dup_sot", {63'b0, err_dup_sot}, {63'b0, m_dup});

            m_hs = (exp_q.size() != 0) && osf_ob_tready;
            w = ob_fifo_rdata;
            if (stat_clr) begin
                m_beat = '0;
                m_frame = '0;
                m_nosot = 1'b0;
                m_dup = 1'b0;
            end else begin
                if (m_hs) begin
                    m_beat = m_beat + 1'b1;
                    if (exp_q[0][65]) m_frame = m_frame + 1'b1;
                end
                if (m_rd && !m_in_frame && !w[64]) m_nosot = 1'b1;
                if (m_rd && m_in_frame && w[64]) m_dup = 1'b1;
            end
            if (m_rd) m_in_frame = !w[65];
            if (m_hs) void'(exp_q.pop_front());
            if (m_rd) exp_q.push_back(w);
            rd_pend = ob_fifo_rd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] user);
        src_mem[wr_idx[7:0]] = {user, data_seq};
        data_seq = data_seq + 64'h0000_0001_0000_0013;
        wr_idx = wr_idx + 1;
    endtask

    task automatic wait_drain(input bit toggle);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            if (toggle) osf_ob_tready = ~osf_ob_tready;
            if (ob_fifo_empty && egress_idle) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got busy expected idle at %0t", $time);
        end
        osf_ob_tready = 1'b1;
    endtask

    task automatic pulse_clr();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        osf_ob_tready = 1'b1;
        stall_req = 1'b0;
        stat_clr = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single 3-word frame: one cycle from pop to tvalid, tlast on word 3 only.
        push_word(8'h01); push_word(8'h00); push_word(8'h02);
        @(negedge clk);
        chk("f1_first_rd", {63'b0, ob_fifo_rd}, 64'd1);
        chk("f1_first_tvalid", {63'b0, osf_ob_tvalid}, 64'd0);
        @(negedge clk);
        chk("f1_lat_tvalid", {63'b0, osf_ob_tvalid}, 64'd1);
        chk("f1_lat_tuser", {56'b0, osf_ob_tuser}, 64'h01);
        step();
        wait_drain(1'b0);
        chk("f1_beat", {60'b0, beat_cnt}, 64'd3);
        chk("f1_frame", {60'b0, frame_cnt}, 64'd1);
        chk("f1_errs", {62'b0, err_no_sot, err_dup_sot}, 64'd0);

        // Back-to-back 4-word frames with tready toggling.
        for (int f = 0; f < 3; f++) begin
            push_word(8'h01); push_word(8'h00); push_word(8'h00); push_word(8'h02);
        end
        osf_ob_tready = 1'b0;
        wait_drain(1'b1);
        chk("bp_beat", {60'b0, beat_cnt}, 64'd15);
        chk("bp_frame", {60'b0, frame_cnt}, 64'd4);
        pulse_clr();
        chk("clr_beat", {60'b0, beat_cnt}, 64'd0);

        // Stall raised on word 2 of 5: the frame finishes, then reading halts.
        push_word(8'h01); push_word(8'h00); push_word(8'h00); push_word(8'h00); push_word(8'h02);
        push_word(8'h01); push_word(8'h02);
        step();
        stall_req = 1'b1;
        repeat (10) step();
        @(negedge clk);
        chk("stall_rd", {63'b0, ob_fifo_rd}, 64'd0);
        chk("stall_empty", {63'b0, ob_fifo_empty}, 64'd0);
        chk("stall_idle", {63'b0, egress_idle}, 64'd1);
        chk("stall_beat", {60'b0, beat_cnt}, 64'd5);
        step();
        stall_req = 1'b0;
        @(negedge clk);
        chk("release_rd", {63'b0, ob_fifo_rd}, 64'd1);
        step();
        wait_drain(1'b0);
        chk("stall_frame", {60'b0, frame_cnt}, 64'd2);

        // Framing errors and their clear.
        pulse_clr();
        push_word(8'h00); push_word(8'h02);
        wait_drain(1'b0);
        chk("nosot_set", {63'b0, err_no_sot}, 64'd1);
        repeat (3) step();
        chk("nosot_sticky", {63'b0, err_no_sot}, 64'd1);
        pulse_clr();
        chk("nosot_clr", {63'b0, err_no_sot}, 64'd0);
        push_word(8'h01); push_word(8'h01); push_word(8'h02);
        wait_drain(1'b0);
        chk("dup_set", {63'b0, err_dup_sot}, 64'd1);
        chk("dup_nosot", {63'b0, err_no_sot}, 64'd0);

        // Counter wrap at 4 bits.
        pulse_clr();
        for (int i = 0; i < 14; i++) push_word(8'h03);
        wait_drain(1'b0);
        chk("wrap_14", {60'b0, beat_cnt}, 64'd14);
        push_word(8'h03); wait_drain(1'b0);
        chk("wrap_15", {60'b0, beat_cnt}, 64'd15);
        push_word(8'h03); wait_drain(1'b0);
        chk("wrap_0", {60'b0, beat_cnt}, 64'd0);
        push_word(8'h03); wait_drain(1'b0);
        chk("wrap_1", {60'b0, beat_cnt}, 64'd1);
        chk("wrap_frame", {60'b0, frame_cnt}, 64'd1);

        // Clear coincident with a handshake wins.
        push_word(8'h03);
        step();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("clr_vs_hs", {60'b0, beat_cnt}, 64'd0);
        wait_drain(1'b0);

        // Reset mid-frame with the buffer full.
        osf_ob_tready = 1'b0;
        push_word(8'h01); push_word(8'h00); push_word(8'h00); push_word(8'h02);
        step(); step();
        chk("pre_rst_tvalid", {63'b0, osf_ob_tvalid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_tvalid", {63'b0, osf_ob_tvalid}, 64'd0);
        step(); step();
        rst = 1'b0;
        osf_ob_tready = 1'b1;
        step();
        push_word(8'h00); push_word(8'h02);
        wait_drain(1'b0);
        chk("post_rst_nosot", {63'b0, err_no_sot}, 64'd1);
        chk("post_rst_beat", {60'b0, beat_cnt}, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
